// File: rtl/cic_pkg.sv
// Shared definitions for the CIC interpolator and decimator: control states and
// register-width helpers used for elaboration-time sizing checks.
package cic_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Minimum internal width so the final integrator never loses information.
  function automatic int cic_nmax(input int nin, input int r, input int m, input int n);
    return nin + n * clog2(r * m);
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// One CIC integrator stage: a registered modulo-2^W accumulator with enable.
module cic_integrator #(
  parameter int W = 21
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic signed [W-1:0] x_i,
  output logic signed [W-1:0] acc_o
);

  logic signed [W-1:0] acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + x_i;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/cic_interp.sv
// N-stage CIC interpolator: low-rate combs on each accepted/injected sample,
// zero-stuff by R, then N integrators running every clk once started.
module cic_interp
  import cic_pkg::*;
#(
  parameter int NIN  = 12,
  parameter int R    = 8,
  parameter int N    = 3,
  parameter int M    = 1,
  parameter int NMAX = 21,
  parameter int NOUT = 21
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIN-1:0]  din,
  input  logic            din_valid,
  output logic            din_ready,
  output logic [NOUT-1:0] dout,
  output logic            dout_valid,
  output logic            underrun
);

  localparam int            PW   = clog2(R);
  localparam logic [PW-1:0] LAST = PW'(R - 1);

  if (NMAX < cic_nmax(NIN, R, M, N)) begin : g_nmax_check
    $error("cic_interp: NMAX too small for NIN, R, M, N");
  end

  state_e                 state_q, state_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic                   run;
  logic                   step;
  logic                   accept;
  logic signed [NMAX-1:0] comb_s   [N+1];
  logic signed [NMAX-1:0] dly_q    [N][M];
  logic signed [NMAX-1:0] comb_out_q;
  logic signed [NMAX-1:0] integ_s  [N+1];
  logic [NOUT-1:0]        dout_q;

  assign run        = (state_q == RUN);
  // A low-rate step happens on every accept, and on every missed slot in RUN.
  assign step       = run ? (phase_q == LAST) : din_valid;
  assign accept     = step & din_valid;
  assign din_ready  = !run || (phase_q == LAST);
  assign dout_valid = run;
  assign underrun   = run && (phase_q == LAST) && !din_valid;
  assign dout       = dout_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    if (run) begin
      phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
    end else if (din_valid) begin
      state_d = RUN;
      phase_d = '0;
    end
  end

  assign comb_s[0] = accept ? NMAX'($signed(din)) : '0;

  for (genvar gi = 0; gi < N; gi++) begin : g_comb
    assign comb_s[gi+1] = comb_s[gi] - dly_q[gi][M-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < M; j++) begin
          dly_q[i][j] <= '0;
        end
      end
      comb_out_q <= '0;
    end else if (step) begin
      for (int i = 0; i < N; i++) begin
        dly_q[i][0] <= comb_s[i];
        for (int j = 1; j < M; j++) begin
          dly_q[i][j] <= dly_q[i][j-1];
        end
      end
      comb_out_q <= comb_s[N];
    end
  end

  // Zero-stuffing: the comb result enters the integrators only in phase 0.
  assign integ_s[0] = (run && phase_q == '0) ? comb_out_q : '0;

  for (genvar gi = 0; gi < N; gi++) begin : g_integ
    cic_integrator #(.W(NMAX)) u_integ (
      .clk  (clk),
      .rst  (rst),
      .en_i (run),
      .x_i  (integ_s[gi]),
      .acc_o(integ_s[gi+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      if (run) begin
        dout_q <= integ_s[N][NMAX-1 -: NOUT];
      end
    end
  end

endmodule

// File: tb/tb_cic_interp.sv
// Self-checking bench for cic_interp: impulse, DC table, handshake cadence,
// underrun, mid-run reset and a looped cosine against a convolution model.
module tb_cic_interp;

  localparam int NIN  = 12;
  localparam int R    = 8;
  localparam int N    = 3;
  localparam int M    = 1;
  localparam int NMAX = 21;
  localparam int NOUT = 21;
  localparam int LAT  = N + 1;
  localparam int HLEN = N * (R * M - 1) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NIN-1:0]  din = '0;
  logic            din_valid = 1'b0;
  logic            din_ready;
  logic [NOUT-1:0] dout;
  logic            dout_valid;
  logic            underrun;

  cic_interp #(.NIN(NIN), .R(R), .N(N), .M(M), .NMAX(NMAX), .NOUT(NOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    x;
    longint t;
  } acc_t;

  typedef struct {
    int din_val;
    int settled;
  } dc_vec_t;

  int      n_cmp = 0;
  int      n_bad = 0;
  longint  cyc = 0;
  longint  last_acc = 0;
  bit      running = 0;
  longint  h [HLEN];
  acc_t    hist [$];
  longint  dout_log [16384];
  int      cos_tab [200];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expected output: upsampled accepted samples convolved with the CIC impulse response.
  function automatic longint model(input longint t);
    longint s;
    longint d;
    s = 0;
    foreach (hist[i]) begin
      d = t - hist[i].t - LAT;
      if (d >= 0 && d < HLEN) s += h[d] * hist[i].x;
    end
    return s;
  endfunction

  task automatic tick();
    logic acc;
    acc = din_valid && din_ready && !rst;
    @(posedge clk);
    cyc++;
    if (rst) begin
      hist.delete();
      running = 0;
    end
    if (acc) begin
      hist.push_back('{x: int'($signed(din)), t: cyc});
      last_acc = cyc;
      running = 1;
    end
    while (hist.size() > 0 && hist[0].t < cyc - LAT - HLEN) void'(hist.pop_front());
    #1;
    if (cyc < 16384) dout_log[cyc] = longint'($signed(dout));
    if (!rst) begin
      check("dout", longint'($signed(dout)), model(cyc));
      check("dout_valid", longint'(dout_valid), longint'(running));
    end
  endtask

  task automatic send(input int x);
    bit done;
    done = 0;
    din = x[NIN-1:0];
    din_valid = 1'b1;
    for (int i = 0; i < 2 * R && !done; i++) begin
      done = din_ready;
      tick();
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dc_vec_t dc_tab [5];
    int      h_exp [HLEN];
    longint  tmp [HLEN];
    longint  peak, sum;
    int      nz, rc, uc, vc, n;
    real     rv;

    dc_tab[0] = '{din_val: 100,   settled: 6400};
    dc_tab[1] = '{din_val: -2048, settled: -131072};
    dc_tab[2] = '{din_val: 2047,  settled: 131008};
    dc_tab[3] = '{din_val: -1,    settled: -64};
    dc_tab[4] = '{din_val: 0,     settled: 0};
    h_exp = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48, 48, 46, 42, 36, 28, 21, 15, 10, 6, 3, 1};

    // Impulse response = coefficients of (1 + z^-1 + ... + z^-(RM-1))^N.
    for (int i = 0; i < HLEN; i++) h[i] = 0;
    h[0] = 1;
    for (int s = 0; s < N; s++) begin
      for (int k = 0; k < HLEN; k++) begin
        tmp[k] = 0;
        for (int i = 0; i < R * M; i++) if (k - i >= 0) tmp[k] += h[k-i];
      end
      for (int k = 0; k < HLEN; k++) h[k] = tmp[k];
    end
    for (int i = 0; i < 200; i++) begin
      rv = 2047.0 * $cos(2.0 * 3.14159265358979 * i / 200.0);
      cos_tab[i] = int'(rv);
    end

    // Reset state
    tick();
    tick();
    check("rst_dout", longint'(dout), 0);
    check("rst_dout_valid", longint'(dout_valid), 0);
    check("rst_din_ready", longint'(din_ready), 1);
    check("rst_underrun", longint'(underrun), 0);
    rst = 1'b0;
    tick();
    check("idle_din_ready", longint'(din_ready), 1);

    // Impulse
    send(1);
    check("impulse_first_accept", last_acc, cyc);
    repeat (4) send(0);
    peak = 0; sum = 0; nz = 0;
    for (int k = 0; k < HLEN; k++) begin
      check($sformatf("impulse_h%0d", k), dout_log[last_acc - 4*R + LAT + k], h_exp[k]);
    end
    for (int k = -1; k <= HLEN; k++) begin
      longint v;
      v = dout_log[last_acc - 4*R + LAT + k];
      if (v > peak) peak = v;
      sum += v;
      if (v != 0) nz++;
    end
    check("impulse_peak", peak, 48);
    check("impulse_nonzero", nz, 22);
    check("impulse_sum", sum, 512);

    // DC table
    foreach (dc_tab[v]) begin
      repeat (6) send(dc_tab[v].din_val);
      for (int i = 0; i < R; i++) begin
        tick();
        check($sformatf("dc_%0d", dc_tab[v].din_val), longint'($signed(dout)), dc_tab[v].settled);
      end
    end

    // Handshake cadence with din_valid held high
    rc = 0; uc = 0; vc = 0;
    din = 12'd9;
    din_valid = 1'b1;
    for (int i = 0; i < 8 * R; i++) begin
      if (din_ready) rc++;
      if (underrun) uc++;
      if (!dout_valid) vc++;
      tick();
    end
    check("cadence_ready_count", rc, 8);
    check("cadence_underrun_count", uc, 0);
    check("cadence_valid_gaps", vc, 0);

    // Underrun on one missed slot
    send(5);
    for (int i = 0; i < R - 1; i++) begin
      check("pre_underrun_ready_low", longint'(din_ready), 0);
      tick();
    end
    check("slot_ready", longint'(din_ready), 1);
    din_valid = 1'b0;
    #1;
    check("underrun_pulse", longint'(underrun), 1);
    tick();
    check("underrun_cleared", longint'(underrun), 0);
    din_valid = 1'b1;
    n = 0; uc = 0;
    while (!din_ready && n < 2 * R) begin
      if (underrun) uc++;
      tick();
      n++;
    end
    check("underrun_next_gap", n, R - 1);
    check("underrun_extra_pulses", uc, 0);
    tick();
    check("underrun_resume_accept", last_acc, cyc);

    // Cosine, looped twice
    for (int i = 0; i < 400; i++) send(cos_tab[i % 200]);

    // Asynchronous reset mid-RUN
    send(300);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_dout", longint'(dout), 0);
    check("arst_dout_valid", longint'(dout_valid), 0);
    check("arst_din_ready", longint'(din_ready), 1);
    repeat (3) tick();
    rst = 1'b0;
    din_valid = 1'b0;
    tick();
    tick();
    check("post_rst_idle_ready", longint'(din_ready), 1);
    check("post_rst_idle_valid", longint'(dout_valid), 0);
    check("post_rst_underrun", longint'(underrun), 0);
    din = 12'd7;
    din_valid = 1'b1;
    tick();
    check("restart_accept", last_acc, cyc);
    n = 0;
    while (!din_ready && n < 2 * R) begin
      tick();
      n++;
    end
    check("restart_phase_gap", n, R - 1);
    repeat (4) send(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cic_interp.md
Name: cic_interp

Overview:
- N-stage CIC interpolator, the transmit-side counterpart of the cic decimator.
- Accepts low-rate samples through a valid/ready handshake, runs N comb stages at the input rate, zero-stuffs by R, and runs N integrator stages at the clk rate.
- Emits one output sample per clk once running. Sits ahead of a DAC/upconverter path, mirroring the decimator in the receive path.

Parameters:
NIN, 12, input sample width, two's complement
R, 8, interpolation factor, power of two, >=2
N, 3, number of comb and integrator stages
M, 1, differential delay of each comb (1 or 2)
NMAX, 21, internal register width; must be >= NIN + N*log2(R*M)
NOUT, 21, output width, <= NMAX; dout = top NOUT bits of the last integrator

Ports:
clk  in  1  single clock; all logic on its rising edge
rst  in  1  asynchronous, active-high reset
din  in  NIN  input sample, two's complement
din_valid  in  1  upstream has a sample on din
din_ready  out  1  block accepts din this cycle when din_valid is also high
dout  out  NOUT  output sample, two's complement
dout_valid  out  1  dout is a valid high-rate sample
underrun  out  1  one-cycle pulse: a sample was due but din_valid was low

Behaviour:
- Interface (fixed): one clock, clk; reset rst is asynchronous and active-high.
- Reset values while rst is high:
  - state=IDLE, phase=0, all comb delay registers, comb_out and integrators = 0.
  - din_ready=1, dout=0, dout_valid=0, underrun=0.
  - Asserting rst mid-operation aborts immediately; any in-flight sample is discarded.
- States: IDLE, RUN.
- IDLE:
  - din_ready=1, dout_valid=0.
  - On din_valid&din_ready: accept, go to RUN, phase=0.
- RUN:
  - phase counts 0..R-1 and wraps to 0; dout_valid=1 every cycle.
  - din_ready=1 only when phase==R-1.
  - At phase==R-1:
    - if din_valid: accept din.
    - else: inject a zero sample, pulse underrun for 1 cycle, stay in RUN.
  - The block never returns to IDLE except via rst.
- Accept cycle:
  - din is sign-extended to NMAX and passed through the comb chain c_k = x_k - x_k delayed by M (per stage, low-rate delay lines).
  - The chain result is registered into comb_out. Comb delay lines update only on accept or zero-inject.
- Zero-stuffing:
  - Integrator 1 input = comb_out in the cycle after an accept or inject, else 0.
  - Each integrator stage is a registered accumulator, I_k <= I_k + I_(k-1), updated every RUN cycle.
- Latency: the first sample's contribution appears on dout N+1 clk edges after the accepting edge. Impulse response length is N*(R*M-1)+1 outputs.
- Arithmetic:
  - All internal arithmetic is NMAX-bit two's complement with modulo wrap (intentional, Hogenauer). No saturation.
  - DC gain = (R*M)^N / R.
  - Truncation to NOUT takes MSBs without rounding.
- Simultaneous events: rst dominates everything; at phase R-1 an accept and an integrator update occur in the same cycle.

Decomposition:
- Package cic_pkg holds:
  - the state enum (IDLE, RUN)
  - a function clog2
  - a function cic_nmax(NIN, R, M, N) used for the NMAX elaboration check, shared with the cic decimator.
- Optional sub-module: cic_integrator (one NMAX-bit registered accumulator with enable), instantiated N times via generate.
- Comb stages stay inline.

Test Plan:
- Reset mid-RUN: assert rst for 3 cycles -> dout=0, dout_valid=0, din_ready=1 immediately (async). After release the block is in IDLE; next accept restarts at phase 0.
- Impulse (defaults):
  - Stimulus: din=1 then zeros, every din_ready.
  - dout after latency N+1 = 1,3,6,10,15,21,28,36,...
  - Peak 48, 22 nonzero samples, sum 512.
- DC:
  - din=100 constant -> settles to dout=6400.
  - din=-2048 -> settles to -131072.
  - Confirm exact values despite internal integrator wrap.
- Handshake cadence: din_valid held high -> din_ready high exactly 1 cycle in 8; dout_valid continuous; underrun never pulses.
- Underrun:
  - Drop din_valid at one phase==R-1 -> underrun=1 for exactly that cycle.
  - Zero injected; RUN continues; the next sample is accepted 8 cycles later.
- Sine:
  - Stimulus: 12-bit cosine table, 200 entries, looped.
  - dout must match a bit-true reference model, cycle-for-cycle.
  - Decimator round trip: feed dout into the cic decimator with matching R, N, M -> recovers the input scaled by (R*M)^(2N)/R after combined latency.
